uart_tx_mmio: RTL

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_mmio.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encodings, register offsets and the STATUS word packing helper.
package uart_tx_mmio_pkg;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
  localparam logic [31:0] UART_STATUS_OFS = 32'd4;

  // STATUS layout: bit0 full, bit1 empty, bit2 busy, bit3 overflow.
  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    return {28'd0, ovf, busy, empty, full};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push while full is accepted only when a
// pop happens in the same cycle, so the occupancy then stays unchanged.
module sync_fifo
  import uart_tx_mmio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop && (count_r != (AW + 1)'(0));
  assign push_ok_s = push && ((count_r != DEPTH_C) || pop_ok_s);

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == (AW + 1)'(0));
  assign count = count_r;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a FIFO,
// STATUS reports full/empty/busy/overflow and clears overflow on write.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0002_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_store,
  input  logic        is_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t state_r, state_nx_s;
  logic [7:0]  shift_r, shift_nx_s;
  logic [2:0]  bit_r, bit_nx_s;
  logic [15:0] baud_r, baud_nx_s;
  logic        tx_r, tx_nx_s;
  logic        busy_r, busy_nx_s;
  logic        ovf_r;

  logic          sel_txdata_s, sel_status_s;
  logic          push_s, pop_s, push_acc_s;
  logic          ovf_set_s, ovf_clr_s, baud_done_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_dout_s;
  logic [CW-1:0] fifo_count_s, count_nx_s;
  logic          unused_wdata_s;

  assign sel_txdata_s = (addr == (BASE_ADDR + UART_TXDATA_OFS));
  assign sel_status_s = (addr == (BASE_ADDR + UART_STATUS_OFS));
  assign hit          = sel_txdata_s || sel_status_s;

  // A load to TXDATA (even with is_store) must not enqueue anything.
  assign push_s      = is_store && !is_load && sel_txdata_s;
  assign pop_s       = (state_r == UART_IDLE) && !fifo_empty_s;
  assign push_acc_s  = push_s && (!fifo_full_s || pop_s);
  assign ovf_set_s   = push_s && !push_acc_s;
  assign ovf_clr_s   = is_store && sel_status_s && wdata[3];
  assign baud_done_s = (baud_r == BAUD_LAST);

  assign unused_wdata_s = ^wdata[31:8];

  assign tx   = tx_r;
  assign busy = busy_r;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (wdata[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // STATUS readback from pre-edge state; every other address reads zero.
  always_comb begin
    rdata = 32'd0;
    if (sel_status_s) begin
      rdata = pack_status(fifo_full_s, fifo_empty_s, busy_r, ovf_r);
    end else begin
      rdata = 32'd0;
    end
  end

  // Frame sequencing: next state, shift/bit/baud counters and the tx level.
  always_comb begin
    state_nx_s = state_r;
    shift_nx_s = shift_r;
    bit_nx_s   = bit_r;
    baud_nx_s  = baud_r;
    case (state_r)
      UART_IDLE: begin
        if (!fifo_empty_s) begin
          state_nx_s = UART_START;
          shift_nx_s = fifo_dout_s;
          bit_nx_s   = 3'd0;
          baud_nx_s  = 16'd0;
        end else begin
          state_nx_s = UART_IDLE;
        end
      end
      UART_START: begin
        if (baud_done_s) begin
          state_nx_s = UART_DATA;
          baud_nx_s  = 16'd0;
        end else begin
          baud_nx_s = baud_r + 16'd1;
        end
      end
      UART_DATA: begin
        if (baud_done_s) begin
          baud_nx_s  = 16'd0;
          shift_nx_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_nx_s = UART_STOP;
            bit_nx_s   = 3'd0;
          end else begin
            bit_nx_s = bit_r + 3'd1;
          end
        end else begin
          baud_nx_s = baud_r + 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_done_s) begin
          state_nx_s = UART_IDLE;
          baud_nx_s  = 16'd0;
        end else begin
          baud_nx_s = baud_r + 16'd1;
        end
      end
      default: begin
        state_nx_s = UART_IDLE;
        baud_nx_s  = 16'd0;
        bit_nx_s   = 3'd0;
      end
    endcase

    case (state_nx_s)
      UART_START: tx_nx_s = 1'b0;
      UART_DATA:  tx_nx_s = shift_nx_s[0];
      default:    tx_nx_s = 1'b1;
    endcase
  end

  // Occupancy after this edge, so busy can be registered without lagging.
  always_comb begin
    count_nx_s = fifo_count_s;
    case ({push_acc_s, pop_s})
      2'b10:   count_nx_s = fifo_count_s + CW'(1);
      2'b01:   count_nx_s = fifo_count_s - CW'(1);
      default: count_nx_s = fifo_count_s;
    endcase
    busy_nx_s = (state_nx_s != UART_IDLE) || (count_nx_s != CW'(0));
  end

  // Transmitter state and registered line/busy outputs; reset aborts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= UART_IDLE;
      shift_r <= 8'd0;
      bit_r   <= 3'd0;
      baud_r  <= 16'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      shift_r <= shift_nx_s;
      bit_r   <= bit_nx_s;
      baud_r  <= baud_nx_s;
      tx_r    <= tx_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  // Sticky overflow; a dropped push in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

endmodule
